// File: rtl/axil_array_pkg.sv
// axil_array_pkg
// Shared definitions for the axil_array word store and the masters that talk
// to it: default address/data widths, word/address typedefs and the channel
// bundle layout (request = master-driven signals, response = array-driven).
// Optional feature macro used by this slice: ARRAY_WRITE_FORWARD_EN
// (write-first behaviour on a same-index read/write collision).
package axil_array_pkg;

    localparam int ADDR_N = 10;
    localparam int INT_N  = 32;

    typedef logic [ADDR_N-1:0] addr_t;
    typedef logic [INT_N-1:0]  word_t;

    // Signals driven by a master into the array.
    typedef struct packed {
        addr_t ra;
        logic  ra_valid;
        logic  rd_ready;
        addr_t wa;
        logic  wa_valid;
        word_t wd;
        logic  wd_valid;
        logic  b_ready;
    } array_req_t;

    // Signals driven by the array back to its master.
    typedef struct packed {
        logic  ra_ready;
        word_t rd;
        logic  rd_valid;
        logic  wa_ready;
        logic  wd_ready;
        logic  b_valid;
    } array_rsp_t;

endpackage

// File: rtl/axil_array_ram.sv
// axil_array_ram
// Simple dual-port RAM: one write port, one read port with a registered read.
// The read register is cleared by reset and only reloads when re is high, so
// it holds its value while the consumer stalls.
// Ports:
//   clk, nrst        clock, synchronous active-low reset (read register only)
//   we, widx, wdata  write enable / index / data
//   re, ridx         read enable / index
//   rdata            registered read data
// Macro ARRAY_WRITE_FORWARD_EN: when defined, a read and a write to the same
// index in one cycle return the new write data; otherwise the old contents.
module axil_array_ram
    import axil_array_pkg::*;
#(
    parameter int N  = 1024,
    parameter int IW = 10,
    parameter int DW = INT_N
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [IW-1:0] ridx,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [N];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Next read-register value: reload on a read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
`ifdef ARRAY_WRITE_FORWARD_EN
            if (we && (widx == ridx)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem[ridx];
            end
`else
            rdata_d = mem[ridx];
`endif
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage array; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    // Read output register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rdata_q <= {DW{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axil_array.sv
// axil_array
// N-word memory behind an AXI-Lite-style valid/ready interface.
// Read: ra/ra_valid/ra_ready in, rd/rd_valid/rd_ready out (1-cycle latency,
//       one-entry output register, one read per cycle while rd_ready=1).
// Write: wa/wa_valid/wa_ready and wd/wd_valid/wd_ready are joined; a write
//        fires only when both are valid and the response slot is free.
//        b_valid/b_ready carry the payload-less write response.
// clk, nrst: rising-edge clock, synchronous active-low reset.
// Addresses wrap modulo N (upper address bits are ignored).
// Macro ARRAY_WRITE_FORWARD_EN selects write-first on same-index collisions.
module axil_array
    import axil_array_pkg::*;
#(
    parameter int N  = 1024,
    parameter int AW = ADDR_N,
    parameter int DW = INT_N
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [AW-1:0] ra,
    input  logic          ra_valid,
    output logic          ra_ready,
    output logic [DW-1:0] rd,
    output logic          rd_valid,
    input  logic          rd_ready,
    input  logic [AW-1:0] wa,
    input  logic          wa_valid,
    output logic          wa_ready,
    input  logic [DW-1:0] wd,
    input  logic          wd_valid,
    output logic          wd_ready,
    output logic          b_valid,
    input  logic          b_ready
);

    localparam int IW = $clog2(N);

    logic rd_valid_q;
    logic rd_valid_d;
    logic b_valid_q;
    logic b_valid_d;
    logic rd_fire;
    logic wr_fire;
    logic ram_we;

    // Handshake decode and next state of the read/response valid flags.
    always_comb begin
        ra_ready = ~rd_valid_q | rd_ready;
        rd_fire  = ra_valid & ra_ready;
        // Address and data are only ever accepted together.
        wr_fire  = wa_valid & wd_valid & (~b_valid_q | b_ready);
        wa_ready = wr_fire;
        wd_ready = wr_fire;
        // A write in the reset cycle must not reach the array.
        ram_we   = wr_fire & nrst;

        rd_valid_d = rd_valid_q;
        if (rd_fire) begin
            rd_valid_d = 1'b1;
        end else if (rd_ready) begin
            rd_valid_d = 1'b0;
        end else begin
            rd_valid_d = rd_valid_q;
        end

        b_valid_d = b_valid_q;
        if (wr_fire) begin
            b_valid_d = 1'b1;
        end else if (b_ready) begin
            b_valid_d = 1'b0;
        end else begin
            b_valid_d = b_valid_q;
        end
    end

    // Valid flag registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_valid_q <= 1'b0;
            b_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            b_valid_q  <= b_valid_d;
        end
    end

    axil_array_ram #(
        .N  (N),
        .IW (IW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .nrst  (nrst),
        .we    (ram_we),
        .widx  (wa[IW-1:0]),
        .wdata (wd),
        .re    (rd_fire),
        .ridx  (ra[IW-1:0]),
        .rdata (rd)
    );

    // Upper address bits only exist when AW exceeds the index width; they
    // are deliberately ignored so addresses wrap.
    if (AW > IW) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^{ra[AW-1:IW], wa[AW-1:IW]};
    end

    assign rd_valid = rd_valid_q;
    assign b_valid  = b_valid_q;

endmodule

// File: tb/tb_axil_array.sv
// tb_axil_array
// Directed bench for axil_array (N=1024, AW=11 so address wrap is visible).
// A behavioural model (array + valid flags) predicts every output each cycle;
// a few literal expectations pin the model.
module tb_axil_array;

    localparam int N  = 1024;
    localparam int AW = 11;
    localparam int DW = 32;
`ifdef ARRAY_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst;
    logic [AW-1:0] ra;
    logic          ra_valid;
    logic          ra_ready;
    logic [DW-1:0] rd;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] wa;
    logic          wa_valid;
    logic          wa_ready;
    logic [DW-1:0] wd;
    logic          wd_valid;
    logic          wd_ready;
    logic          b_valid;
    logic          b_ready;

    always #5 clk = ~clk;

    axil_array #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .nrst(nrst),
        .ra(ra), .ra_valid(ra_valid), .ra_ready(ra_ready),
        .rd(rd), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wa(wa), .wa_valid(wa_valid), .wa_ready(wa_ready),
        .wd(wd), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .b_valid(b_valid), .b_ready(b_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int b_seen = 0;
    bit checking = 1'b0;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mmem [N];
    bit            m_rdv = 1'b0;
    bit            m_bv  = 1'b0;
    logic [DW-1:0] m_rd  = '0;
    bit            m_rf;
    bit            m_wf;
    logic [DW-1:0] m_old;

    function automatic int idx(input logic [AW-1:0] a);
        return int'(a) % N;
    endfunction

    assign m_rf  = ra_valid && (!m_rdv || rd_ready);
    assign m_wf  = wa_valid && wd_valid && (!m_bv || b_ready);
    assign m_old = mmem[idx(ra)];

    always @(posedge clk) begin
        if (!nrst) begin
            m_rdv <= 1'b0;
            m_bv  <= 1'b0;
            m_rd  <= '0;
        end else begin
            if (m_wf) mmem[idx(wa)] <= wd;
            if (m_rf) begin
                m_rd  <= (FWD && m_wf && idx(ra) == idx(wa)) ? wd : m_old;
                m_rdv <= 1'b1;
            end else if (rd_ready) begin
                m_rdv <= 1'b0;
            end
            if (m_wf) m_bv <= 1'b1;
            else if (b_ready) m_bv <= 1'b0;
        end
    end

    task automatic check_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check_b("rd_valid", rd_valid, m_rdv);
            check_b("b_valid",  b_valid,  m_bv);
            check_w("rd",       rd,       m_rd);
            check_b("ra_ready", ra_ready, !m_rdv || rd_ready);
            check_b("wa_ready", wa_ready, m_wf);
            check_b("wd_ready", wd_ready, m_wf);
            if (b_valid && b_ready) b_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] v);
        ra       = a;
        ra_valid = 1'b1;
        tick();
        ra_valid = 1'b0;
        v        = rd;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wa       = a;
        wd       = d;
        wa_valid = 1'b1;
        wd_valid = 1'b1;
        tick();
        wa_valid = 1'b0;
        wd_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        nrst = 1'b0; ra = '0; ra_valid = 1'b0; rd_ready = 1'b1;
        wa = '0; wa_valid = 1'b0; wd = '0; wd_valid = 1'b0; b_ready = 1'b1;

        tick();
        checking = 1'b1;
        check_b("reset_rd_valid", rd_valid, 1'b0);
        check_b("reset_b_valid",  b_valid,  1'b0);
        check_w("reset_rd",       rd,       32'd0);
        tick();
        nrst = 1'b1;

        // Fill mem[i]=i with idle gaps and lone-address cycles.
        for (int i = 0; i < N; i++) begin
            write_word(AW'(i), DW'(i));
            case ($urandom_range(0, 2))
                0: ;
                1: tick();
                default: begin
                    wa = AW'($urandom_range(0, 2047));
                    wa_valid = 1'b1;
                    tick();
                    wa_valid = 1'b0;
                end
            endcase
        end
        tick();
        tick();
        check_w("fill_b_count", 32'(b_seen), 32'd1024);

        // Back-to-back readback.
        for (int i = 0; i < N; i++) begin
            ra = AW'(i);
            ra_valid = 1'b1;
            tick();
        end
        ra_valid = 1'b0;
        check_w("readback_last", rd, 32'd1023);
        tick();

        // Backpressure at address 5.
        rd_ready = 1'b0;
        read_word(AW'(5), v);
        ra = AW'(6);
        ra_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_b("bp_ra_ready", ra_ready, 1'b0);
            check_w("bp_rd_hold", rd, 32'd5);
        end
        rd_ready = 1'b1;
        #1;
        check_b("bp_release_ready", ra_ready, 1'b1);
        tick();
        ra_valid = 1'b0;
        check_w("bp_next_read", rd, 32'd6);
        tick();

        // Wrap: 1024+7 aliases index 7.
        write_word(AW'(1031), 32'h0000_ABCD);
        read_word(AW'(7), v);
        check_w("wrap_read7", v, 32'h0000_ABCD);

        // Same-cycle collision at address 3.
        ra = AW'(3); wa = AW'(3); wd = 32'd99;
        ra_valid = 1'b1; wa_valid = 1'b1; wd_valid = 1'b1;
        tick();
        ra_valid = 1'b0; wa_valid = 1'b0; wd_valid = 1'b0;
        check_w("collision_rd", rd, FWD ? 32'd99 : 32'd3);
        read_word(AW'(3), v);
        check_w("collision_after", v, 32'd99);

        // Reset with both responses pending and a write presented.
        rd_ready = 1'b0;
        b_ready  = 1'b0;
        ra = AW'(5); ra_valid = 1'b1;
        write_word(AW'(20), 32'h0000_0055);
        ra_valid = 1'b0;
        tick();
        check_b("pre_reset_rd_valid", rd_valid, 1'b1);
        check_b("pre_reset_b_valid",  b_valid,  1'b1);
        nrst = 1'b0;
        b_ready = 1'b1;
        wa = AW'(10); wd = 32'h0000_DEAD; wa_valid = 1'b1; wd_valid = 1'b1;
        tick();
        check_b("mid_reset_rd_valid", rd_valid, 1'b0);
        check_b("mid_reset_b_valid",  b_valid,  1'b0);
        check_w("mid_reset_rd",       rd,       32'd0);
        nrst = 1'b1;
        wa_valid = 1'b0; wd_valid = 1'b0;
        rd_ready = 1'b1;
        tick();
        read_word(AW'(10), v);
        check_w("reset_suppressed_write", v, 32'd10);
        read_word(AW'(20), v);
        check_w("reset_preserved", v, 32'h0000_0055);
        tick();
        tick();

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
